// File: rtl/xadac_pkg.sv
// Shared xadac types and system defaults used by the accelerator units and
// the AXI write-channel arbiter.
package xadac_pkg;

  localparam int unsigned XadacIdW      = 4;
  localparam int unsigned XadacAddrW    = 32;
  localparam int unsigned XadacVecDataW = 64;
  localparam int unsigned XadacVecStrbW = XadacVecDataW / 8;

  typedef logic [XadacIdW-1:0]      IdT;
  typedef logic [XadacAddrW-1:0]    AddrT;
  typedef logic [XadacVecDataW-1:0] VecDataT;
  typedef logic [XadacVecStrbW-1:0] VecStrbT;

  // Single-beat write payload as carried on a W channel.
  typedef struct packed {
    VecDataT data;
    VecStrbT strb;
  } xadac_w_beat_t;

  localparam int unsigned XadacArbNumReq     = 2;
  localparam int unsigned XadacArbOrderDepth = 4;

endpackage

// File: rtl/xadac_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head data is visible
// combinationally whenever the FIFO is non-empty.
module xadac_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/xadac_axi_wr_arb.sv
// Shares one AXI write port among several xadac units: round-robin AW grant,
// W beats forwarded in grant order, B routed back by the index tag in the ID.
module xadac_axi_wr_arb
  import xadac_pkg::*;
#(
  parameter  int unsigned NumReq     = XadacArbNumReq,
  parameter  int unsigned OrderDepth = XadacArbOrderDepth,
  localparam int unsigned IdxW       = $clog2(NumReq),
  localparam int unsigned MIdW       = IdxW + $bits(IdT)
) (
  input  logic                    clk,
  input  logic                    rstn,
  // upstream AW
  input  IdT      [NumReq-1:0]    s_aw_id_i,
  input  AddrT    [NumReq-1:0]    s_aw_addr_i,
  input  logic    [NumReq-1:0]    s_aw_valid_i,
  output logic    [NumReq-1:0]    s_aw_ready_o,
  // upstream W
  input  VecDataT [NumReq-1:0]    s_w_data_i,
  input  VecStrbT [NumReq-1:0]    s_w_strb_i,
  input  logic    [NumReq-1:0]    s_w_valid_i,
  output logic    [NumReq-1:0]    s_w_ready_o,
  // upstream B
  output IdT                      s_b_id_o,
  output logic    [NumReq-1:0]    s_b_valid_o,
  input  logic    [NumReq-1:0]    s_b_ready_i,
  // downstream AW
  output logic    [MIdW-1:0]      m_aw_id_o,
  output AddrT                    m_aw_addr_o,
  output logic                    m_aw_valid_o,
  input  logic                    m_aw_ready_i,
  // downstream W
  output VecDataT                 m_w_data_o,
  output VecStrbT                 m_w_strb_o,
  output logic                    m_w_valid_o,
  input  logic                    m_w_ready_i,
  // downstream B
  input  logic    [MIdW-1:0]      m_b_id_i,
  input  logic                    m_b_valid_i,
  output logic                    m_b_ready_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic            lock_q, lock_d;

  logic [IdxW-1:0] sel_idx;
  logic [IdxW-1:0] cand;
  logic            sel_found;
  int unsigned     scan;

  logic            do_sel;
  logic            aw_active;
  logic [IdxW-1:0] cur_gnt;
  logic            aw_hs;

  logic [IdxW-1:0] w_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            w_pop;

  logic [IdxW-1:0] b_idx;

  // Round-robin scan starting at ptr, wrapping past NumReq-1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    scan      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan = 32'(ptr_q) + i;
      if (scan >= NumReq) scan = scan - NumReq;
      cand = IdxW'(scan);
      if (!sel_found && s_aw_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // A new selection only starts when unlocked and the W order has room.
  assign do_sel    = !lock_q && !fifo_full && sel_found;
  assign aw_active = lock_q || do_sel;
  assign cur_gnt   = lock_q ? gnt_q : sel_idx;

  assign m_aw_valid_o = aw_active && s_aw_valid_i[cur_gnt];
  assign m_aw_id_o    = {cur_gnt, s_aw_id_i[cur_gnt]};
  assign m_aw_addr_o  = s_aw_addr_i[cur_gnt];
  assign aw_hs        = m_aw_valid_o && m_aw_ready_i;

  always_comb begin
    s_aw_ready_o = '0;
    if (aw_active) s_aw_ready_o[cur_gnt] = m_aw_ready_i;
  end

  always_comb begin
    lock_d = lock_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    if (aw_hs) begin
      lock_d = 1'b0;
      ptr_d  = (cur_gnt == IdxW'(NumReq - 1)) ? '0 : cur_gnt + IdxW'(1);
    end else if (do_sel) begin
      lock_d = 1'b1;
      gnt_d  = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
    end
  end

  // Order is recorded at selection so W may run ahead of its AW handshake.
  xadac_fifo #(
    .WIDTH (IdxW),
    .DEPTH (OrderDepth)
  ) u_order_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (do_sel),
    .data_i  (sel_idx),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_w_valid_o = !fifo_empty && s_w_valid_i[w_head];
  assign m_w_data_o  = s_w_data_i[w_head];
  assign m_w_strb_o  = s_w_strb_i[w_head];
  assign w_pop       = m_w_valid_o && m_w_ready_i;

  always_comb begin
    s_w_ready_o = '0;
    if (!fifo_empty) s_w_ready_o[w_head] = m_w_ready_i;
  end

  // B routing by the index tag; out-of-range tags are accepted and dropped.
  assign b_idx    = m_b_id_i[MIdW-1 -: IdxW];
  assign s_b_id_o = m_b_id_i[$bits(IdT)-1:0];

  always_comb begin
    s_b_valid_o = '0;
    m_b_ready_o = 1'b1;
    if (32'(b_idx) < NumReq) begin
      s_b_valid_o[b_idx] = m_b_valid_i;
      m_b_ready_o        = s_b_ready_i[b_idx];
    end
  end

endmodule

// File: tb/tb_xadac_axi_wr_arb.sv
// Directed bench for xadac_axi_wr_arb: behavioural upstream masters, an
// expectation scoreboard for downstream AW/W handshakes, and direct B checks.
module tb_xadac_axi_wr_arb;
  import xadac_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned MIdW  = 1 + $bits(IdT);
  localparam int unsigned NR3   = 3;
  localparam int unsigned MIdW3 = 2 + $bits(IdT);

  typedef struct packed { IdT id; AddrT addr; } aw_req_t;
  typedef struct packed { logic [MIdW-1:0] id; AddrT addr; } aw_exp_t;

  logic clk;
  logic rstn;

  IdT      [NR-1:0] s_aw_id;
  AddrT    [NR-1:0] s_aw_addr;
  logic    [NR-1:0] s_aw_valid, s_aw_ready;
  VecDataT [NR-1:0] s_w_data;
  VecStrbT [NR-1:0] s_w_strb;
  logic    [NR-1:0] s_w_valid, s_w_ready;
  IdT               s_b_id;
  logic    [NR-1:0] s_b_valid, s_b_ready;
  logic [MIdW-1:0]  m_aw_id;
  AddrT             m_aw_addr;
  logic             m_aw_valid, m_aw_ready;
  VecDataT          m_w_data;
  VecStrbT          m_w_strb;
  logic             m_w_valid, m_w_ready;
  logic [MIdW-1:0]  m_b_id;
  logic             m_b_valid, m_b_ready;

  IdT      [NR3-1:0] s_aw_id3;
  AddrT    [NR3-1:0] s_aw_addr3;
  logic    [NR3-1:0] s_aw_valid3, s_aw_ready3;
  VecDataT [NR3-1:0] s_w_data3;
  VecStrbT [NR3-1:0] s_w_strb3;
  logic    [NR3-1:0] s_w_valid3, s_w_ready3;
  IdT                s_b_id3;
  logic    [NR3-1:0] s_b_valid3, s_b_ready3;
  logic [MIdW3-1:0]  m_aw_id3;
  AddrT              m_aw_addr3;
  logic              m_aw_valid3;
  VecDataT           m_w_data3;
  VecStrbT           m_w_strb3;
  logic              m_w_valid3;
  logic [MIdW3-1:0]  m_b_id3;
  logic              m_b_valid3, m_b_ready3;

  aw_req_t       aw_q0[$], aw_q1[$];
  xadac_w_beat_t w_q0[$], w_q1[$];
  aw_exp_t       exp_aw[$];
  xadac_w_beat_t exp_w[$];
  logic [NR-1:0] hs_aw, hs_w;

  int checks = 0;
  int errors = 0;
  int n_gnt0 = 0;
  int n_gnt1 = 0;

  xadac_axi_wr_arb #(.NumReq(NR), .OrderDepth(4)) dut (
    .clk(clk), .rstn(rstn),
    .s_aw_id_i(s_aw_id), .s_aw_addr_i(s_aw_addr), .s_aw_valid_i(s_aw_valid),
    .s_aw_ready_o(s_aw_ready),
    .s_w_data_i(s_w_data), .s_w_strb_i(s_w_strb), .s_w_valid_i(s_w_valid),
    .s_w_ready_o(s_w_ready),
    .s_b_id_o(s_b_id), .s_b_valid_o(s_b_valid), .s_b_ready_i(s_b_ready),
    .m_aw_id_o(m_aw_id), .m_aw_addr_o(m_aw_addr), .m_aw_valid_o(m_aw_valid),
    .m_aw_ready_i(m_aw_ready),
    .m_w_data_o(m_w_data), .m_w_strb_o(m_w_strb), .m_w_valid_o(m_w_valid),
    .m_w_ready_i(m_w_ready),
    .m_b_id_i(m_b_id), .m_b_valid_i(m_b_valid), .m_b_ready_o(m_b_ready)
  );

  // Three-requester instance: exercises non-power-of-two index range on B.
  xadac_axi_wr_arb #(.NumReq(NR3), .OrderDepth(4)) dut3 (
    .clk(clk), .rstn(rstn),
    .s_aw_id_i(s_aw_id3), .s_aw_addr_i(s_aw_addr3), .s_aw_valid_i(s_aw_valid3),
    .s_aw_ready_o(s_aw_ready3),
    .s_w_data_i(s_w_data3), .s_w_strb_i(s_w_strb3), .s_w_valid_i(s_w_valid3),
    .s_w_ready_o(s_w_ready3),
    .s_b_id_o(s_b_id3), .s_b_valid_o(s_b_valid3), .s_b_ready_i(s_b_ready3),
    .m_aw_id_o(m_aw_id3), .m_aw_addr_o(m_aw_addr3), .m_aw_valid_o(m_aw_valid3),
    .m_aw_ready_i(1'b0),
    .m_w_data_o(m_w_data3), .m_w_strb_o(m_w_strb3), .m_w_valid_o(m_w_valid3),
    .m_w_ready_i(1'b0),
    .m_b_id_i(m_b_id3), .m_b_valid_i(m_b_valid3), .m_b_ready_o(m_b_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input int r, input IdT id, input AddrT addr,
                          input VecDataT d, input VecStrbT s);
    aw_req_t a;
    xadac_w_beat_t w;
    a.id = id; a.addr = addr; w.data = d; w.strb = s;
    if (r == 0) begin aw_q0.push_back(a); w_q0.push_back(w); end
    else        begin aw_q1.push_back(a); w_q1.push_back(w); end
  endtask

  // Queue a request and its expected downstream AW/W in grant order.
  task automatic txn(input int r, input IdT id, input AddrT addr,
                     input VecDataT d, input VecStrbT s);
    aw_exp_t e;
    xadac_w_beat_t w;
    push_req(r, id, addr, d, s);
    e.id = {1'(r), id}; e.addr = addr; w.data = d; w.strb = s;
    exp_aw.push_back(e);
    exp_w.push_back(w);
  endtask

  task automatic update();
    if (hs_aw[0] && aw_q0.size() > 0) aw_q0.delete(0);
    if (hs_aw[1] && aw_q1.size() > 0) aw_q1.delete(0);
    if (hs_w[0] && w_q0.size() > 0) w_q0.delete(0);
    if (hs_w[1] && w_q1.size() > 0) w_q1.delete(0);
    hs_aw = '0;
    hs_w  = '0;
    s_aw_valid[0] = (aw_q0.size() > 0);
    s_aw_valid[1] = (aw_q1.size() > 0);
    s_w_valid[0]  = (w_q0.size() > 0);
    s_w_valid[1]  = (w_q1.size() > 0);
    if (aw_q0.size() > 0) begin s_aw_id[0] = aw_q0[0].id; s_aw_addr[0] = aw_q0[0].addr; end
    if (aw_q1.size() > 0) begin s_aw_id[1] = aw_q1[0].id; s_aw_addr[1] = aw_q1[0].addr; end
    if (w_q0.size() > 0) begin s_w_data[0] = w_q0[0].data; s_w_strb[0] = w_q0[0].strb; end
    if (w_q1.size() > 0) begin s_w_data[1] = w_q1[0].data; s_w_strb[1] = w_q1[0].strb; end
  endtask

  task automatic flush();
    aw_q0.delete(); aw_q1.delete(); w_q0.delete(); w_q1.delete();
    exp_aw.delete(); exp_w.delete();
    hs_aw = '0; hs_w = '0;
    update();
  endtask

  // One clock: sample handshakes at negedge, advance masters after posedge.
  task automatic tick();
    aw_exp_t ea;
    xadac_w_beat_t ew;
    @(negedge clk);
    hs_aw = s_aw_valid & s_aw_ready;
    hs_w  = s_w_valid & s_w_ready;
    if (m_aw_valid && m_aw_ready) begin
      if (m_aw_id[MIdW-1]) n_gnt1++; else n_gnt0++;
      chk("aw_expected", exp_aw.size() > 0, 64'(exp_aw.size()), 64'd1);
      if (exp_aw.size() > 0) begin
        ea = exp_aw.pop_front();
        chk("aw_id", m_aw_id === ea.id, 64'(m_aw_id), 64'(ea.id));
        chk("aw_addr", m_aw_addr === ea.addr, 64'(m_aw_addr), 64'(ea.addr));
      end
    end
    if (m_w_valid && m_w_ready) begin
      chk("w_expected", exp_w.size() > 0, 64'(exp_w.size()), 64'd1);
      if (exp_w.size() > 0) begin
        ew = exp_w.pop_front();
        chk("w_data", m_w_data === ew.data, m_w_data, ew.data);
        chk("w_strb", m_w_strb === ew.strb, 64'(m_w_strb), 64'(ew.strb));
      end
    end
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_aw.size() == 0 && exp_w.size() == 0) break;
      tick();
    end
    chk(tag, (exp_aw.size() + exp_w.size()) === 0,
        64'(exp_aw.size() + exp_w.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    m_aw_ready = 1'b0; m_w_ready = 1'b0;
    m_b_id = '0; m_b_valid = 1'b0; s_b_ready = '0;
    s_aw_id = '0; s_aw_addr = '0; s_w_data = '0; s_w_strb = '0;
    s_aw_id3 = '0; s_aw_addr3 = '0; s_aw_valid3 = '0;
    s_w_data3 = '0; s_w_strb3 = '0; s_w_valid3 = '0;
    s_b_ready3 = '0; m_b_id3 = '0; m_b_valid3 = 1'b0;
    flush();
    #2;
    chk("rst_m_aw_valid", m_aw_valid === 1'b0, 64'(m_aw_valid), 64'd0);
    chk("rst_m_w_valid", m_w_valid === 1'b0, 64'(m_w_valid), 64'd0);
    chk("rst_s_aw_ready", s_aw_ready === 2'b00, 64'(s_aw_ready), 64'd0);
    chk("rst_s_w_ready", s_w_ready === 2'b00, 64'(s_w_ready), 64'd0);
    chk("rst_s_b_valid", s_b_valid === 2'b00, 64'(s_b_valid), 64'd0);
    do_reset();

    // Single requester, full AW/W/B round trip.
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    txn(0, 4'h3, 32'h0000_1000, 64'hA5A5_0000_1111_2222, 8'h0F);
    update();
    #2;
    chk("t1_aw_valid", m_aw_valid === 1'b1, 64'(m_aw_valid), 64'd1);
    chk("t1_aw_id", m_aw_id === 5'h03, 64'(m_aw_id), 64'h03);
    chk("t1_w_before_push", m_w_valid === 1'b0, 64'(m_w_valid), 64'd0);
    drain("t1_drain");
    m_b_id = 5'h03; m_b_valid = 1'b1; s_b_ready = 2'b01;
    #1;
    chk("t1_b_valid", s_b_valid === 2'b01, 64'(s_b_valid), 64'h1);
    chk("t1_b_id", s_b_id === 4'h3, 64'(s_b_id), 64'h3);
    chk("t1_b_ready", m_b_ready === 1'b1, 64'(m_b_ready), 64'd1);
    s_b_ready = 2'b10;
    #1;
    chk("b_ready_routed", m_b_ready === 1'b0, 64'(m_b_ready), 64'd0);
    m_b_id = 5'h15;
    #1;
    chk("b_valid_req1", s_b_valid === 2'b10, 64'(s_b_valid), 64'h2);
    chk("b_id_req1", s_b_id === 4'h5, 64'(s_b_id), 64'h5);
    chk("b_ready_req1", m_b_ready === 1'b1, 64'(m_b_ready), 64'd1);
    m_b_valid = 1'b0;
    #1;
    chk("b_idle", s_b_valid === 2'b00, 64'(s_b_valid), 64'd0);

    // Both requesters busy every cycle: strict alternation, 4 grants each.
    do_reset();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    n_gnt0 = 0; n_gnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      txn(0, IdT'(i), 32'h0001_0000 + 32'(i * 16), 64'h0A00 + 64'(i), 8'hF0);
      txn(1, IdT'(i + 8), 32'h0002_0000 + 32'(i * 16), 64'h0B00 + 64'(i), 8'h0F);
    end
    update();
    drain("t2_drain");
    chk("t2_gnt0", n_gnt0 === 4, 64'(n_gnt0), 64'd4);
    chk("t2_gnt1", n_gnt1 === 4, 64'(n_gnt1), 64'd4);

    // AW stall: grant held on req0 while req1 appears mid-stall.
    do_reset();
    m_aw_ready = 1'b0; m_w_ready = 1'b0;
    txn(0, 4'h1, 32'h0000_2000, 64'h2000, 8'hFF);
    update();
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("t3_aw_valid", m_aw_valid === 1'b1, 64'(m_aw_valid), 64'd1);
      chk("t3_aw_id", m_aw_id === 5'h01, 64'(m_aw_id), 64'h01);
      chk("t3_aw_addr", m_aw_addr === 32'h0000_2000, 64'(m_aw_addr), 64'h2000);
      chk("t3_aw_ready_req1", s_aw_ready[1] === 1'b0, 64'(s_aw_ready[1]), 64'd0);
      if (c == 1) begin
        txn(1, 4'h2, 32'h0000_3000, 64'h3000, 8'h3C);
        update();
      end
      tick();
    end
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    drain("t3_drain");

    // Slave waits for WVALID before AWREADY.
    do_reset();
    m_aw_ready = 1'b0; m_w_ready = 1'b1;
    txn(0, 4'h6, 32'h0000_4000, 64'h4444, 8'h81);
    update();
    #2;
    chk("t4_aw_valid_sel", m_aw_valid === 1'b1, 64'(m_aw_valid), 64'd1);
    chk("t4_w_not_yet", m_w_valid === 1'b0, 64'(m_w_valid), 64'd0);
    tick();
    #2;
    chk("t4_w_ahead", m_w_valid === 1'b1, 64'(m_w_valid), 64'd1);
    chk("t4_aw_held", m_aw_valid === 1'b1, 64'(m_aw_valid), 64'd1);
    tick();
    #2;
    chk("t4_w_done", m_w_valid === 1'b0, 64'(m_w_valid), 64'd0);
    chk("t4_aw_still", m_aw_valid === 1'b1, 64'(m_aw_valid), 64'd1);
    m_aw_ready = 1'b1;
    drain("t4_drain");

    // Order FIFO full: fifth AW waits until one W beat pops.
    do_reset();
    m_aw_ready = 1'b1; m_w_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      txn(0, IdT'(i + 2), 32'h0000_6000 + 32'(i * 4), 64'h6000 + 64'(i), 8'hFF);
    update();
    repeat (4) tick();
    #2;
    chk("t5_full_no_aw", m_aw_valid === 1'b0, 64'(m_aw_valid), 64'd0);
    chk("t5_full_aw_ready", s_aw_ready === 2'b00, 64'(s_aw_ready), 64'd0);
    chk("t5_req_pending", s_aw_valid[0] === 1'b1, 64'(s_aw_valid[0]), 64'd1);
    chk("t5_exp_left", exp_aw.size() === 1, 64'(exp_aw.size()), 64'd1);
    m_w_ready = 1'b1;
    #1;
    chk("t5_pop_w", m_w_valid === 1'b1, 64'(m_w_valid), 64'd1);
    chk("t5_pop_no_push", m_aw_valid === 1'b0, 64'(m_aw_valid), 64'd0);
    tick();
    #2;
    chk("t5_after_pop", m_aw_valid === 1'b1, 64'(m_aw_valid), 64'd1);
    drain("t5_drain");

    // Reset mid-lock discards lock, pointer and order FIFO.
    do_reset();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    txn(0, 4'h2, 32'h0000_7000, 64'h7000, 8'h11);
    update();
    drain("t6_pre");
    m_aw_ready = 1'b0; m_w_ready = 1'b0;
    push_req(1, 4'h9, 32'h0000_8000, 64'h8000, 8'h22);
    update();
    tick();
    #2;
    chk("t6_locked_id", m_aw_id === 5'h19, 64'(m_aw_id), 64'h19);
    chk("t6_w_queued", m_w_valid === 1'b1, 64'(m_w_valid), 64'd1);
    m_w_ready = 1'b1;
    rstn = 1'b0;
    #1;
    chk("t6_rst_w_valid", m_w_valid === 1'b0, 64'(m_w_valid), 64'd0);
    chk("t6_rst_w_ready", s_w_ready === 2'b00, 64'(s_w_ready), 64'd0);
    flush();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_aw_ready = 1'b1;
    txn(0, 4'h4, 32'h0000_9000, 64'h9000, 8'h33);
    txn(1, 4'h5, 32'h0000_A000, 64'hA000, 8'h44);
    update();
    #2;
    chk("t6_ptr_reset", m_aw_id === 5'h04, 64'(m_aw_id), 64'h04);
    drain("t6_drain");

    // Out-of-range B index on the three-requester instance.
    m_b_id3 = 6'h35; m_b_valid3 = 1'b1; s_b_ready3 = 3'b000;
    #1;
    chk("b3_drop_ready", m_b_ready3 === 1'b1, 64'(m_b_ready3), 64'd1);
    chk("b3_drop_valid", s_b_valid3 === 3'b000, 64'(s_b_valid3), 64'd0);
    m_b_id3 = 6'h27;
    #1;
    chk("b3_route_valid", s_b_valid3 === 3'b100, 64'(s_b_valid3), 64'h4);
    chk("b3_route_id", s_b_id3 === 4'h7, 64'(s_b_id3), 64'h7);
    chk("b3_route_ready", m_b_ready3 === 1'b0, 64'(m_b_ready3), 64'd0);
    s_b_ready3 = 3'b100;
    #1;
    chk("b3_route_ready_hi", m_b_ready3 === 1'b1, 64'(m_b_ready3), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
